// File: rtl/axis_pkt_streamer.sv
// PL-to-PS AXI-Stream transmitter: FWFT beat FIFO, forced tlast at a maximum
// packet length, stretched per-packet read interrupt and status counters.
module axis_pkt_streamer #(
    parameter int                    DATA_WIDTH       = 256,
    parameter int                    KEEP_WIDTH       = DATA_WIDTH / 8,
    parameter int                    FIFO_DEPTH_INDEX = 4,
    parameter int                    MAX_PKT_BEATS    = 400,
    parameter logic [KEEP_WIDTH-1:0] LAST_KEEP        = '1,
    parameter int                    INTR_PERIOD      = 10,
    parameter int                    PKT_CNT_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        transmit_vld,
    input  logic [DATA_WIDTH-1:0]       transmit_data,
    input  logic                        transmit_last,
    output logic                        transmit_rdy,
    output logic [DATA_WIDTH-1:0]       AXIS_tdata,
    output logic [KEEP_WIDTH-1:0]       AXIS_tkeep,
    output logic                        AXIS_tlast,
    output logic                        AXIS_tvalid,
    input  logic                        AXIS_tready,
    output logic                        read_intr,
    output logic [PKT_CNT_WIDTH-1:0]    pkt_cnt,
    output logic [FIFO_DEPTH_INDEX:0]   fifo_level
);

    localparam int DEPTH   = 2 ** FIFO_DEPTH_INDEX;
    localparam int BEAT_W  = (MAX_PKT_BEATS > 1) ? $clog2(MAX_PKT_BEATS) : 1;
    localparam int TIMER_W = (INTR_PERIOD > 0) ? $clog2(INTR_PERIOD + 1) : 1;

    localparam logic [FIFO_DEPTH_INDEX:0]   LEVEL_FULL = (FIFO_DEPTH_INDEX + 1)'(DEPTH);
    localparam logic [FIFO_DEPTH_INDEX:0]   LEVEL_ONE  = 1;
    localparam logic [FIFO_DEPTH_INDEX-1:0] PTR_ONE    = 1;
    localparam logic [BEAT_W-1:0]           BEAT_MAX   = BEAT_W'(MAX_PKT_BEATS - 1);
    localparam logic [BEAT_W-1:0]           BEAT_ONE   = 1;
    localparam logic [TIMER_W-1:0]          TIMER_LOAD = TIMER_W'(INTR_PERIOD);
    localparam logic [TIMER_W-1:0]          TIMER_ONE  = 1;
    localparam logic [PKT_CNT_WIDTH-1:0]    PKT_ONE    = 1;

    logic [DATA_WIDTH:0]         mem [DEPTH];
    logic [FIFO_DEPTH_INDEX-1:0] wr_ptr;
    logic [FIFO_DEPTH_INDEX-1:0] rd_ptr;
    logic [FIFO_DEPTH_INDEX:0]   level;
    logic [BEAT_W-1:0]           beat_cnt;
    logic [TIMER_W-1:0]          timer;
    logic                        wr_en;
    logic                        rd_en;
    logic                        in_last;
    logic                        head_last;

    // Handshakes in a flush cycle are dropped, so flush gates both enables.
    assign transmit_rdy = (level != LEVEL_FULL);
    assign AXIS_tvalid  = (level != '0);
    assign wr_en        = transmit_vld && transmit_rdy && !flush;
    assign rd_en        = AXIS_tvalid && AXIS_tready && !flush;
    assign in_last      = transmit_last || (beat_cnt == BEAT_MAX);
    assign head_last    = mem[rd_ptr][DATA_WIDTH];

    // Head entry drives the stream directly; it only moves on a read, which keeps it stable under backpressure.
    assign AXIS_tdata   = AXIS_tvalid ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;
    assign AXIS_tlast   = AXIS_tvalid && head_last;
    assign AXIS_tkeep   = AXIS_tlast ? LAST_KEEP : '1;
    assign read_intr    = (timer != '0);
    assign fifo_level   = level;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {in_last, transmit_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (flush) begin
            beat_cnt <= '0;
        end else if (wr_en) begin
            beat_cnt <= in_last ? '0 : beat_cnt + BEAT_ONE;
        end
    end

    // pkt_cnt survives flush; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else if (rd_en && head_last) begin
            pkt_cnt <= pkt_cnt + PKT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (flush) begin
            timer <= '0;
        end else if (rd_en && head_last) begin
            timer <= TIMER_LOAD;
        end else if (timer != '0) begin
            timer <= timer - TIMER_ONE;
        end
    end

endmodule

// File: tb/tb_axis_pkt_streamer.sv
// Scoreboard bench for axis_pkt_streamer: stimulus pushes expected beats,
// a negedge monitor compares stream outputs and status against a reference model.
module tb_axis_pkt_streamer;

    localparam int             DW    = 32;
    localparam int             KW    = 4;
    localparam int             DI    = 4;
    localparam int             DEPTH = 16;
    localparam int             MAXB  = 4;
    localparam int             INTR  = 10;
    localparam int             PW    = 16;
    localparam logic [KW-1:0]  LK    = 4'b0011;

    logic           clk;
    logic           rst_n;
    logic           flush;
    logic           transmit_vld;
    logic [DW-1:0]  transmit_data;
    logic           transmit_last;
    logic           transmit_rdy;
    logic [DW-1:0]  AXIS_tdata;
    logic [KW-1:0]  AXIS_tkeep;
    logic           AXIS_tlast;
    logic           AXIS_tvalid;
    logic           AXIS_tready;
    logic           read_intr;
    logic [PW-1:0]  pkt_cnt;
    logic [DI:0]    fifo_level;

    axis_pkt_streamer #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .FIFO_DEPTH_INDEX(DI), .MAX_PKT_BEATS(MAXB),
        .LAST_KEEP(LK), .INTR_PERIOD(INTR), .PKT_CNT_WIDTH(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .transmit_vld(transmit_vld), .transmit_data(transmit_data),
        .transmit_last(transmit_last), .transmit_rdy(transmit_rdy),
        .AXIS_tdata(AXIS_tdata), .AXIS_tkeep(AXIS_tkeep), .AXIS_tlast(AXIS_tlast),
        .AXIS_tvalid(AXIS_tvalid), .AXIS_tready(AXIS_tready),
        .read_intr(read_intr), .pkt_cnt(pkt_cnt), .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int             total = 0;
    int             bad   = 0;
    logic [DW:0]    sb_q[$];
    int             mdl_level = 0;
    int             mdl_beat  = 0;
    int             mdl_timer = 0;
    logic [PW-1:0]  mdl_pkt   = '0;
    int             intr_high = 0;
    int             intr_rise = 0;
    int             out_lasts = 0;
    int             in_accepts = 0;
    logic           prev_intr = 1'b0;
    logic           prev_stall = 1'b0;
    logic [DW-1:0]  prev_data = '0;
    logic           prev_tlast = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor: compare against model state, then advance the model for the coming edge.
    always @(negedge clk) begin : monitor
        logic        wr;
        logic        rd;
        logic        loaded;
        logic        lst;
        logic [DW:0] item;
        if (!rst_n) begin
            checkOutput("rst_transmit_rdy", 64'(transmit_rdy), 64'(1));
            checkOutput("rst_tvalid", 64'(AXIS_tvalid), 64'(0));
            checkOutput("rst_tlast", 64'(AXIS_tlast), 64'(0));
            checkOutput("rst_tdata", 64'(AXIS_tdata), 64'(0));
            checkOutput("rst_tkeep", 64'(AXIS_tkeep), 64'(4'hF));
            checkOutput("rst_read_intr", 64'(read_intr), 64'(0));
            checkOutput("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
            checkOutput("rst_fifo_level", 64'(fifo_level), 64'(0));
            sb_q.delete();
            mdl_level  = 0;
            mdl_beat   = 0;
            mdl_timer  = 0;
            mdl_pkt    = '0;
            prev_stall = 1'b0;
        end else begin
            checkOutput("transmit_rdy", 64'(transmit_rdy), 64'(mdl_level != DEPTH));
            checkOutput("tvalid", 64'(AXIS_tvalid), 64'(mdl_level != 0));
            checkOutput("fifo_level", 64'(fifo_level), 64'(mdl_level));
            checkOutput("pkt_cnt", 64'(pkt_cnt), 64'(mdl_pkt));
            checkOutput("read_intr", 64'(read_intr), 64'(mdl_timer != 0));
            if (mdl_level != 0 && sb_q.size() != 0) begin
                item = sb_q[0];
                checkOutput("tdata", 64'(AXIS_tdata), 64'(item[DW-1:0]));
                checkOutput("tlast", 64'(AXIS_tlast), 64'(item[DW]));
                checkOutput("tkeep", 64'(AXIS_tkeep), 64'(item[DW] ? LK : 4'hF));
            end else begin
                checkOutput("idle_tdata", 64'(AXIS_tdata), 64'(0));
                checkOutput("idle_tlast", 64'(AXIS_tlast), 64'(0));
                checkOutput("idle_tkeep", 64'(AXIS_tkeep), 64'(4'hF));
            end
            if (prev_stall) begin
                checkOutput("stall_tdata_stable", 64'(AXIS_tdata), 64'(prev_data));
                checkOutput("stall_tlast_stable", 64'(AXIS_tlast), 64'(prev_tlast));
            end
            if (read_intr) intr_high++;
            if (read_intr && !prev_intr) intr_rise++;

            wr         = transmit_vld && (mdl_level != DEPTH) && !flush;
            rd         = (mdl_level != 0) && AXIS_tready && !flush;
            prev_stall = AXIS_tvalid && !AXIS_tready && !flush;
            prev_data  = AXIS_tdata;
            prev_tlast = AXIS_tlast;
            if (flush) begin
                sb_q.delete();
                mdl_level = 0;
                mdl_beat  = 0;
                mdl_timer = 0;
            end else begin
                loaded = 1'b0;
                if (rd) begin
                    item = sb_q.pop_front();
                    mdl_level--;
                    if (item[DW]) begin
                        mdl_pkt++;
                        out_lasts++;
                        mdl_timer = INTR;
                        loaded = 1'b1;
                    end
                end
                if (!loaded && mdl_timer > 0) mdl_timer--;
                if (wr) begin
                    lst = transmit_last || (mdl_beat == MAXB - 1);
                    sb_q.push_back({lst, transmit_data});
                    mdl_beat = lst ? 0 : mdl_beat + 1;
                    mdl_level++;
                    in_accepts++;
                end
            end
        end
        prev_intr = read_intr;
    end

    // Offer one beat and hold it until the DUT accepts it; returns just after the accepting edge.
    task automatic applyStimulus(input logic [DW-1:0] data, input logic last);
        logic accepted;
        int   waited;
        transmit_vld  = 1'b1;
        transmit_data = data;
        transmit_last = last;
        accepted = 1'b0;
        waited   = 0;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            accepted = transmit_rdy && !flush;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!accepted) checkOutput("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle(input int n);
        transmit_vld  = 1'b0;
        transmit_last = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int cycles;
        rst_n = 1'b0; flush = 1'b0; transmit_vld = 1'b0;
        transmit_data = '0; transmit_last = 1'b0; AXIS_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] three-beat packet");
        AXIS_tready = 1'b1;
        intr_high = 0; intr_rise = 0;
        applyStimulus(32'hA000_0001, 1'b0);
        applyStimulus(32'hA000_0002, 1'b0);
        applyStimulus(32'hA000_0003, 1'b1);
        idle(20);
        checkOutput("p1_intr_cycles", 64'(intr_high), 64'(10));
        checkOutput("p1_intr_edges", 64'(intr_rise), 64'(1));
        checkOutput("p1_pkt_cnt", 64'(pkt_cnt), 64'(1));

        $display("[TB] fill to full with tready low");
        AXIS_tready = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(32'hB000_0000 + 32'(i), 1'b0);
        transmit_vld = 1'b1; transmit_data = 32'hB000_0010; transmit_last = 1'b1;
        @(negedge clk);
        checkOutput("full_transmit_rdy", 64'(transmit_rdy), 64'(0));
        checkOutput("full_fifo_level", 64'(fifo_level), 64'(16));
        repeat (2) @(posedge clk);
        #1 AXIS_tready = 1'b1;
        @(negedge clk);
        checkOutput("full_no_write_through", 64'(transmit_rdy), 64'(0));
        @(posedge clk);
        #1;
        applyStimulus(32'hB000_0010, 1'b1);
        idle(30);
        checkOutput("p2_pkt_cnt", 64'(pkt_cnt), 64'(6));

        $display("[TB] forced tlast at max length");
        out_lasts = 0;
        for (int i = 0; i < 10; i++) applyStimulus(32'hC000_0000 + 32'(i), i == 9);
        idle(30);
        checkOutput("p3_tlast_count", 64'(out_lasts), 64'(3));
        checkOutput("p3_pkt_cnt", 64'(pkt_cnt), 64'(9));

        $display("[TB] interrupt reload");
        intr_high = 0; intr_rise = 0;
        applyStimulus(32'hD000_0001, 1'b1);
        idle(4);
        applyStimulus(32'hD000_0002, 1'b1);
        idle(30);
        checkOutput("p4_intr_cycles", 64'(intr_high), 64'(15));
        checkOutput("p4_intr_edges", 64'(intr_rise), 64'(1));
        checkOutput("p4_pkt_cnt", 64'(pkt_cnt), 64'(11));

        $display("[TB] flush");
        AXIS_tready = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(32'hE000_0000 + 32'(i), 1'b0);
        idle(1);
        flush = 1'b1; AXIS_tready = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_fifo_level", 64'(fifo_level), 64'(0));
        checkOutput("flush_tvalid", 64'(AXIS_tvalid), 64'(0));
        checkOutput("flush_pkt_cnt", 64'(pkt_cnt), 64'(11));
        checkOutput("flush_transmit_rdy", 64'(transmit_rdy), 64'(1));
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) applyStimulus(32'hE100_0000 + 32'(i), 1'b0);
        idle(20);
        checkOutput("p5_pkt_cnt", 64'(pkt_cnt), 64'(12));

        $display("[TB] reset mid-packet");
        AXIS_tready = 1'b0;
        applyStimulus(32'hF000_0000, 1'b0);
        applyStimulus(32'hF000_0001, 1'b0);
        transmit_vld = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        AXIS_tready = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(32'hF100_0000 + 32'(i), 1'b0);
        idle(20);
        checkOutput("p6_pkt_cnt", 64'(pkt_cnt), 64'(1));

        $display("[TB] random traffic");
        out_lasts  = 0;
        in_accepts = 0;
        cycles     = 0;
        while (in_accepts < 1000 && cycles < 20000) begin
            AXIS_tready   = 1'($urandom_range(0, 1));
            transmit_vld  = 1'($urandom_range(0, 1));
            transmit_data = $urandom;
            transmit_last = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            #1;
            cycles++;
        end
        transmit_vld = 1'b0;
        AXIS_tready  = 1'b1;
        idle(40);
        checkOutput("rand_accepts_done", 64'(in_accepts >= 1000), 64'(1));
        checkOutput("rand_scoreboard_empty", 64'(sb_q.size()), 64'(0));
        checkOutput("rand_pkt_cnt", 64'(pkt_cnt), 64'(1 + out_lasts));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_pkt_streamer.md
Name: axis_pkt_streamer

Overview:
Parametrised successor to the PL-to-PS AXI-Stream transmitter. It buffers beats from the PL processing chain (transmit_* handshake) in a FWFT FIFO and drives an AXI-Stream master into the PS DMA slave. It enforces a maximum packet length by forcing tlast, and generates a stretched per-packet read interrupt for the PS GPIO. It also exposes packet-count and FIFO-level status.

Parameters:
DATA_WIDTH, 256, tdata/transmit_data width in bits (multiple of 8)
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
FIFO_DEPTH_INDEX, 4, FIFO holds 2**FIFO_DEPTH_INDEX beats
MAX_PKT_BEATS, 400, maximum beats per packet; tlast forced on beat MAX_PKT_BEATS (≥1)
LAST_KEEP, all ones (KEEP_WIDTH bits), tkeep value on tlast beats
INTR_PERIOD, 10, read_intr high time in clk cycles after each packet; 0 disables
PKT_CNT_WIDTH, 16, width of pkt_cnt

Ports:
clk  in  1  system clock (clk_50M domain)
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of FIFO, beat counter and interrupt timer
transmit_vld  in  1  input beat valid
transmit_data  in  DATA_WIDTH  input beat data
transmit_last  in  1  input end-of-packet
transmit_rdy  out  1  input ready
AXIS_tdata  out  DATA_WIDTH  stream data
AXIS_tkeep  out  KEEP_WIDTH  byte enables
AXIS_tlast  out  1  stream end-of-packet
AXIS_tvalid  out  1  stream valid
AXIS_tready  in  1  stream ready from DMA
read_intr  out  1  packet-complete interrupt, level, stretched
pkt_cnt  out  PKT_CNT_WIDTH  packets delivered, wraps
fifo_level  out  FIFO_DEPTH_INDEX+1  beats currently stored

Behaviour:
- Reset: all pointers, counters and timer = 0. Outputs: transmit_rdy=1, AXIS_tvalid=0, AXIS_tlast=0, AXIS_tdata=0, AXIS_tkeep=all ones, read_intr=0, pkt_cnt=0, fifo_level=0.
- FIFO: entry = {last, data}. Write on transmit_vld&&transmit_rdy; read on AXIS_tvalid&&AXIS_tready.
- transmit_rdy = (fifo_level != 2**FIFO_DEPTH_INDEX). No write-through when full: a simultaneous read frees the slot only from the next cycle.
- FWFT output: AXIS_tvalid = (fifo_level != 0). AXIS_tdata/AXIS_tlast come from the head entry. Write-to-tvalid latency is 1 cycle; there is no empty bypass. When tvalid=0, tdata and tlast hold 0.
- Simultaneous read and write when neither full nor empty: level unchanged, both pointers advance. Pointers wrap modulo depth.
- AXIS_tdata/tlast must remain stable while tvalid=1 and tready=0 (AXIS rule).
- AXIS_tkeep = AXIS_tlast ? LAST_KEEP : all ones.
- Beat counter: counts accepted input beats of the current packet (0..MAX_PKT_BEATS-1).
  - Stored last = transmit_last || (beat_cnt == MAX_PKT_BEATS-1).
  - The counter clears after any stored last; otherwise it increments per accepted beat.
  - With MAX_PKT_BEATS=1, every beat is last.
- pkt_cnt: increments on each output handshake with tlast=1; wraps from all ones to 0. It is not cleared by flush.
- Interrupt timer:
  - On an output tlast handshake, the timer loads INTR_PERIOD. Otherwise it decrements while nonzero.
  - read_intr = (timer != 0), so it rises in the cycle after the handshake.
  - A new tlast while the timer is running reloads it; there is no second edge.
  - INTR_PERIOD=0 keeps read_intr at 0.
- flush (synchronous, highest priority after reset): empties the FIFO (level=0), clears beat_cnt and the timer.
  - Input and output handshakes in the flush cycle are discarded: no pkt_cnt increment, no timer load.
  - transmit_rdy is 1 in the following cycle.
- Reset mid-packet: everything returns to reset values immediately. A partial packet is lost; the next accepted beat starts a new packet.

Test Plan:
- Reset then 3-beat packet (last on beat 3), tready=1 → tvalid rises 1 cycle after first write; 3 beats out in order; tlast on beat 3 with tkeep=LAST_KEEP; pkt_cnt=1; read_intr high exactly 10 cycles.
- tready=0, 17 input beats offered at depth 16 → 16 accepted; transmit_rdy=0 and fifo_level=16; beat 17 accepted only in the cycle after the first tready=1 read.
- MAX_PKT_BEATS=4, input 10 beats with transmit_last only on beat 10 → output tlast on beats 4, 8, 10; pkt_cnt=3.
- Two packets whose tlast handshakes are 5 cycles apart, INTR_PERIOD=10 → read_intr continuously high 15 cycles, single rising edge; pkt_cnt=2.
- Load 5 beats, assert flush one cycle with tready=1 → fifo_level=0 and tvalid=0 next cycle; pkt_cnt unchanged; next packet starts at beat_cnt 0.
- Random vld/tready at 50% for 1000 beats with random last → output sequence equals input sequence; tlast count equals pkt_cnt; data is never changed while stalled.
